io_port: RTL and testbench
==========================

// Module: io_port
// PURPOSE
//  Bus-slave I/O peripheral; the responding end of the control unit's io_oe/io_we bus protocol.
//  Address comes from AM. Bus writes push words into a TX FIFO drained by an external valid/ready sink.
//  An external valid/ready source fills an RX FIFO, which bus reads pop. STATUS/CTRL registers sit at fixed offsets.
// PARAMETERS
//  word_width  16      bus/data word width
//  IO_BASE     16'hFF00 base address; offsets +0 DATA, +1 STATUS, +2 CTRL; other addresses ignored
//  FIFO_DEPTH  4       entries per FIFO (power of 2, >=2)
//  PTR_W       2       log2(FIFO_DEPTH)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-low reset
//  addr       in   word_width  address (AM output)
//  bus_in     in   word_width  data bus value during io_we
//  bus_out    out  word_width  read data; top-level bus mux selects it when io_oe=1
//  io_oe      in   1           bus read strobe, one cycle per access
//  io_we      in   1           bus write strobe, one cycle per access
//  tx_data    out  word_width  TX FIFO head
//  tx_valid   out  1           TX FIFO non-empty and CTRL.tx_en=1
//  tx_ready   in   1           sink accepts; pop when tx_valid&tx_ready
//  rx_data    in   word_width  external source word
//  rx_valid   in   1           source offers rx_data
//  rx_ready   out  1           RX FIFO not full; push when rx_valid&rx_ready
// BEHAVIOUR
//  Reset (rst=0, async): FIFOs empty, pointers/counts 0, CTRL=0, sticky flags 0; bus_out=0, tx_valid=0, rx_ready=1.
//  Hit = io_oe|io_we with addr in IO_BASE..IO_BASE+2. Non-hit accesses: no state change, bus_out=0.
//  Read latency 0: bus_out is combinational while io_oe=1 (RI/regs capture it on the same edge).
//   DATA: bus_out=RX head, pop on that clock edge. If RX empty: bus_out=0, no pop, set rd_unf.
//   STATUS: {.., tx_cnt[PTR_W:0] @[10:8], rd_unf@5, wr_ovf@4, rx_empty@3, rx_full@2, tx_empty@1, tx_full@0}; unused bits 0.
//   CTRL: reads back the CTRL register.
//  Writes take effect on the edge where io_we=1.
//   DATA: push bus_in to TX FIFO. If full: drop the word, set wr_ovf.
//   CTRL: bit0 tx_en is stored. bit1 clears the RX FIFO and bit2 clears both sticky flags; both are self-clearing and read 0.
//   STATUS write: ignored.
//  io_oe&io_we together: the write is performed, the read is ignored (no pop), bus_out=0.
//  Simultaneous push+pop in one cycle on the same FIFO: both happen, count unchanged.
//   If full, the pop frees a slot, so the push succeeds and no overflow is flagged.
//   If empty, the push is accepted and the pop does not occur.
//  RX clear and an external push in the same cycle: the clear wins and the pushed word is lost.
//  Pointers wrap modulo FIFO_DEPTH; count is PTR_W+1 bits (0..FIFO_DEPTH).
//  tx_en=0 holds tx_valid low; the FIFO still fills from the bus.
//  Async reset mid-transfer: all state discarded immediately; outputs take their reset values.
// CONFIGURATION
//  IO_PORT_IRQ_EN defined: extra output irq (1 bit, registered, reset 0).
//   CTRL bit3 = rx_irq_en, bit4 = tx_irq_en.
//   irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty), updated every cycle.
//  Not defined: no irq port; CTRL bits 3-4 read 0 and writes to them are ignored.
// STRUCTURE
//  Shared package/header io_defs.vh: offset `defines (IO_OFS_DATA/STATUS/CTRL), STATUS and CTRL bit indices.
//  Sub-module io_fifo (parameters word_width, PTR_W): push/pop/clr inputs, head, full, empty, count.
//  Instantiated twice (TX, RX). io_port holds only decode, CTRL, sticky flags, bus_out mux.
// TESTING
//  1 Reset, then read STATUS -> 16'h000A (tx_empty, rx_empty); rx_ready=1, tx_valid=0.
//  2 tx_en=1, tx_ready=0; write 5 words 1..5 to DATA -> first 4 stored, STATUS wr_ovf=1, tx_full=1.
//    Then tx_ready=1 -> tx_data sequence 1,2,3,4.
//  3 Source drives 16'hA5A5, then 16'h5A5A. Two DATA reads return A5A5 then 5A5A.
//    A third read returns 0 and sets rd_unf; CTRL write 16'h0004 clears it.
//  4 RX full and a DATA read with rx_valid=1 in the same cycle -> pop and push both occur.
//    Count stays 4, order preserved.
//  5 Assert rst=0 mid-way through a 3-word TX burst, between clock edges.
//    -> tx_valid drops without waiting for a clock; after release STATUS = 16'h000A.
//  6 (IO_PORT_IRQ_EN) CTRL=16'h0009, one RX word -> irq=1 next cycle; DATA read -> irq=0 after the pop.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared constants for io_port: register offsets and STATUS/CTRL bit positions.
package io_port_pkg;

  typedef enum logic [1:0] {
    IO_OFS_DATA   = 2'd0,
    IO_OFS_STATUS = 2'd1,
    IO_OFS_CTRL   = 2'd2
  } io_ofs_e;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;
  localparam int unsigned ST_WR_OVF   = 4;
  localparam int unsigned ST_RD_UNF   = 5;
  localparam int unsigned ST_TX_CNT   = 8;

  localparam int unsigned CT_TX_EN     = 0;
  localparam int unsigned CT_RX_CLR    = 1;
  localparam int unsigned CT_FLAG_CLR  = 2;
  localparam int unsigned CT_RX_IRQ_EN = 3;
  localparam int unsigned CT_TX_IRQ_EN = 4;

endpackage

// File: rtl/io_port_fifo.sv
// Synchronous FIFO for io_port; a pop on a full FIFO frees the slot for a same-cycle push.
module io_fifo #(
  parameter int unsigned word_width = 16,
  parameter int unsigned PTR_W      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr,
  input  logic [word_width-1:0] din,
  output logic [word_width-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count
);

  logic [word_width-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/io_port.sv
// Bus-slave I/O port: DATA/STATUS/CTRL at IO_BASE..IO_BASE+2 fronting a TX and an RX FIFO.
// Define IO_PORT_IRQ_EN to add the registered irq output and the CTRL irq enables.
module io_port
  import io_port_pkg::*;
#(
  parameter int unsigned           word_width = 16,
  parameter logic [word_width-1:0] IO_BASE    = 16'hFF00,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] bus_in,
  output logic [word_width-1:0] bus_out,
  input  logic                  io_oe,
  input  logic                  io_we,
  output logic [word_width-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [word_width-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
`ifdef IO_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

`ifdef IO_PORT_IRQ_EN
  localparam logic [word_width-1:0] CTRL_MASK = word_width'(5'h19);
`else
  localparam logic [word_width-1:0] CTRL_MASK = word_width'(5'h01);
`endif

  logic [word_width-1:0] ofs;
  io_ofs_e               sel;
  logic                  hit, rd_acc, wr_acc;
  logic [word_width-1:0] ctrl;
  logic                  wr_ovf, rd_unf;
  logic [word_width-1:0] status;

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [PTR_W:0]        tx_cnt;
  logic                  rx_push, rx_pop, rx_clr, rx_full, rx_empty;
  logic [word_width-1:0] rx_head;
  logic [PTR_W:0]        rx_cnt_unused;
  logic                  flag_clr;

  // Unsigned offset wraps for addresses below IO_BASE, so one compare covers both ends.
  assign ofs    = addr - IO_BASE;
  assign hit    = (io_oe | io_we) && (ofs < word_width'(3));
  assign sel    = io_ofs_e'(ofs[1:0]);
  assign wr_acc = hit & io_we;
  assign rd_acc = hit & io_oe & ~io_we;

  assign tx_push  = wr_acc && (sel == IO_OFS_DATA);
  assign tx_valid = ~tx_empty & ctrl[CT_TX_EN];
  assign tx_pop   = tx_valid & tx_ready;

  assign rx_pop   = rd_acc && (sel == IO_OFS_DATA) && !rx_empty;
  assign rx_ready = ~rx_full | rx_pop;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_clr   = wr_acc && (sel == IO_OFS_CTRL) && bus_in[CT_RX_CLR];
  assign flag_clr = wr_acc && (sel == IO_OFS_CTRL) && bus_in[CT_FLAG_CLR];

  io_fifo #(.word_width(word_width), .PTR_W(PTR_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .clr   (1'b0),
    .din   (bus_in),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  io_fifo #(.word_width(word_width), .PTR_W(PTR_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .clr   (rx_clr),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt_unused)
  );

  always_comb begin
    status                          = '0;
    status[ST_TX_CNT +: PTR_W+1]    = tx_cnt;
    status[ST_RD_UNF]               = rd_unf;
    status[ST_WR_OVF]               = wr_ovf;
    status[ST_RX_EMPTY]             = rx_empty;
    status[ST_RX_FULL]              = rx_full;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_TX_FULL]              = tx_full;
  end

  // Zero-latency read mux; a combined read+write strobe is treated as a write only.
  always_comb begin
    bus_out = '0;
    if (rd_acc) begin
      case (sel)
        IO_OFS_DATA:   bus_out = rx_empty ? '0 : rx_head;
        IO_OFS_STATUS: bus_out = status;
        IO_OFS_CTRL:   bus_out = ctrl;
        default:       bus_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= '0;
      wr_ovf <= 1'b0;
      rd_unf <= 1'b0;
    end else begin
      if (wr_acc && (sel == IO_OFS_CTRL)) ctrl <= bus_in & CTRL_MASK;
      if (flag_clr) begin
        wr_ovf <= 1'b0;
        rd_unf <= 1'b0;
      end else begin
        if (tx_push && tx_full && !tx_pop) wr_ovf <= 1'b1;
        if (rd_acc && (sel == IO_OFS_DATA) && rx_empty) rd_unf <= 1'b1;
      end
    end
  end

`ifdef IO_PORT_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (ctrl[CT_RX_IRQ_EN] & ~rx_empty) | (ctrl[CT_TX_IRQ_EN] & tx_empty);
  end
`endif

endmodule

// File: tb/tb_io_port.sv
// Randomized and directed bench for io_port against a queue-based register/FIFO model.
module tb_io_port;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 4;
`ifdef IO_PORT_IRQ_EN
  localparam logic [15:0] CMASK = 16'h0019;
`else
  localparam logic [15:0] CMASK = 16'h0001;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, bus_in, bus_out, tx_data, rx_data;
  logic        io_oe, io_we, tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef IO_PORT_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] m_ctrl;
  bit          m_wr_ovf, m_rd_unf, m_irq;

  always #5 clk = ~clk;

  io_port dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .io_oe    (io_oe),
    .io_we    (io_we),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
`ifdef IO_PORT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int m_ofs();
    int a = int'(addr) - int'(BASE);
    if ((io_oe || io_we) && a >= 0 && a <= 2) return a;
    return -1;
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s = '0;
    s[10:8] = 3'(tx_q.size());
    s[5] = m_rd_unf;
    s[4] = m_wr_ovf;
    s[3] = (rx_q.size() == 0);
    s[2] = (rx_q.size() == DEPTH);
    s[1] = (tx_q.size() == 0);
    s[0] = (tx_q.size() == DEPTH);
    return s;
  endfunction

  function automatic bit m_rx_pop();
    return io_oe && !io_we && m_ofs() == 0 && rx_q.size() > 0;
  endfunction

  function automatic bit m_rx_ready();
    return (rx_q.size() < DEPTH) || m_rx_pop();
  endfunction

  function automatic bit m_tx_valid();
    return m_ctrl[0] && tx_q.size() > 0;
  endfunction

  function automatic logic [15:0] m_bus_out();
    int o = m_ofs();
    if (!io_oe || io_we || o < 0) return 16'h0000;
    if (o == 0) return (rx_q.size() > 0) ? rx_q[0] : 16'h0000;
    if (o == 1) return m_status();
    return m_ctrl;
  endfunction

  function automatic void model_edge();
    int o     = m_ofs();
    bit tpop  = m_tx_valid() && tx_ready;
    bit rpop  = m_rx_pop();
    bit rpush = rx_valid && m_rx_ready();
    m_irq = (m_ctrl[3] && rx_q.size() > 0) || (m_ctrl[4] && tx_q.size() == 0);
    if (io_oe && !io_we && o == 0 && rx_q.size() == 0) m_rd_unf = 1'b1;
    if (tpop) void'(tx_q.pop_front());
    if (io_we && o == 0) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(bus_in);
      else m_wr_ovf = 1'b1;
    end
    if (rpop) void'(rx_q.pop_front());
    if (rpush) rx_q.push_back(rx_data);
    if (io_we && o == 2) begin
      m_ctrl = bus_in & CMASK;
      if (bus_in[1]) rx_q.delete();
      if (bus_in[2]) begin
        m_wr_ovf = 1'b0;
        m_rd_unf = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl   = '0;
    m_wr_ovf = 1'b0;
    m_rd_unf = 1'b0;
    m_irq    = 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    io_we = 1'b1; addr = a; bus_in = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    io_oe = 1'b1; addr = a;
    #1;
    d = bus_out;
    tick();
    io_oe = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b0; io_oe = 0; io_we = 0; addr = '0; bus_in = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    model_reset();
    #2;
    checks++;
    if (bus_out !== 16'h0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got bus_out=%h tx_valid=%b rx_ready=%b expected 0000 0 1", bus_out, tx_valid, rx_ready);
    end
`ifdef IO_PORT_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
    #10 rst = 1'b1;
    @(posedge clk); #1;
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h000A) begin failures++; $display("FAIL reset_status: got %h expected 000A", d); end
  endtask

  task automatic test_tx_overflow();
    logic [15:0] d;
    tx_ready = 1'b0;
    bus_write(BASE + 16'd2, 16'h0001);
    for (int i = 1; i <= 5; i++) bus_write(BASE, 16'(i));
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h0419) begin failures++; $display("FAIL tx_ovf_status: got %h expected 0419", d); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
        failures++;
        $display("FAIL tx_drain_%0d: got valid=%b data=%h expected 1 %h", i, tx_valid, tx_data, 16'(i));
      end
      tick();
    end
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained_valid: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    bus_write(BASE + 16'd2, 16'h0004);
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h000A) begin failures++; $display("FAIL tx_ovf_cleared: got %h expected 000A", d); end
  endtask

  task automatic test_rx_read();
    logic [15:0] d;
    rx_valid = 1'b1; rx_data = 16'hA5A5; tick();
    rx_data = 16'h5A5A; tick();
    rx_valid = 1'b0;
    bus_read(BASE, d);
    checks++;
    if (d !== 16'hA5A5) begin failures++; $display("FAIL rx_read1: got %h expected A5A5", d); end
    bus_read(BASE, d);
    checks++;
    if (d !== 16'h5A5A) begin failures++; $display("FAIL rx_read2: got %h expected 5A5A", d); end
    bus_read(BASE, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL rx_read_empty: got %h expected 0000", d); end
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h002A) begin failures++; $display("FAIL rd_unf_set: got %h expected 002A", d); end
    bus_write(BASE + 16'd2, 16'h0004);
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h000A) begin failures++; $display("FAIL rd_unf_clear: got %h expected 000A", d); end
  endtask

  task automatic test_rx_full_simul();
    logic [15:0] w[5];
    logic [15:0] d;
    for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin rx_data = w[i]; tick(); end
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
    rx_valid = 1'b1; rx_data = w[4]; io_oe = 1'b1; addr = BASE;
    #1;
    checks++;
    if (rx_ready !== 1'b1 || bus_out !== w[0]) begin
      failures++;
      $display("FAIL rx_full_popush: got ready=%b data=%h expected 1 %h", rx_ready, bus_out, w[0]);
    end
    tick();
    io_oe = 1'b0; rx_valid = 1'b0;
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h0006) begin failures++; $display("FAIL rx_still_full: got %h expected 0006", d); end
    for (int i = 1; i < 5; i++) begin
      bus_read(BASE, d);
      checks++;
      if (d !== w[i]) begin failures++; $display("FAIL rx_order_%0d: got %h expected %h", i, d, w[i]); end
    end
  endtask

  task automatic test_clear_and_nonhit();
    logic [15:0] d;
    rx_valid = 1'b1; rx_data = 16'h1111; tick(); tick();
    rx_data = 16'h2222;
    bus_write(BASE + 16'd2, 16'h0002);
    rx_valid = 1'b0;
    bus_write(BASE + 16'd3, 16'hBEEF);
    bus_write(BASE - 16'd1, 16'hBEEF);
    bus_write(BASE + 16'd1, 16'hFFFF);
    io_oe = 1'b1; addr = BASE + 16'd3; #1;
    checks++;
    if (bus_out !== 16'h0) begin failures++; $display("FAIL nonhit_read: got %h expected 0000", bus_out); end
    tick(); io_oe = 1'b0;
    io_oe = 1'b1; io_we = 1'b1; addr = BASE + 16'd1; bus_in = 16'h0000; #1;
    checks++;
    if (bus_out !== 16'h0) begin failures++; $display("FAIL oe_we_read: got %h expected 0000", bus_out); end
    tick(); io_oe = 1'b0; io_we = 1'b0;
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h000A) begin failures++; $display("FAIL clear_nonhit_status: got %h expected 000A", d); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    tx_ready = 1'b0;
    bus_write(BASE + 16'd2, 16'h0001);
    for (int i = 0; i < 3; i++) bus_write(BASE, 16'(16'h0100 + i));
    tx_ready = 1'b1;
    tick();
    #3;
    checks++;
    if (tx_valid !== 1'b1) begin failures++; $display("FAIL burst_valid: got %b expected 1", tx_valid); end
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || bus_out !== 16'h0) begin
      failures++;
      $display("FAIL async_reset: got tx_valid=%b rx_ready=%b bus_out=%h expected 0 1 0000", tx_valid, rx_ready, bus_out);
    end
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    bus_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h000A) begin failures++; $display("FAIL post_reset_status: got %h expected 000A", d); end
  endtask

  task automatic test_random();
    logic [15:0] exp_bus;
    bit          exp_rdy, exp_vld;
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      int k = $urandom_range(0, 4);
      io_oe = (r <= 2) || (r == 6);
      io_we = (r >= 3 && r <= 6);
      addr  = (k == 4) ? 16'($urandom) : BASE + 16'(k);
      bus_in = 16'($urandom);
      if ($urandom_range(0, 3) != 0) bus_in[2:1] = 2'b00;
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 16'($urandom);
      #1;
      exp_bus = m_bus_out();
      exp_rdy = m_rx_ready();
      exp_vld = m_tx_valid();
      checks++;
      if (bus_out !== exp_bus || rx_ready !== exp_rdy || tx_valid !== exp_vld) begin
        failures++;
        $display("FAIL rand_%0d: got bus_out=%h rx_ready=%b tx_valid=%b expected %h %b %b",
                 n, bus_out, rx_ready, tx_valid, exp_bus, exp_rdy, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (tx_data !== tx_q[0]) begin
          failures++;
          $display("FAIL rand_txdata_%0d: got %h expected %h", n, tx_data, tx_q[0]);
        end
      end
`ifdef IO_PORT_IRQ_EN
      checks++;
      if (irq !== m_irq) begin failures++; $display("FAIL rand_irq_%0d: got %b expected %b", n, irq, m_irq); end
`endif
      tick();
    end
    io_oe = 1'b0; io_we = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

`ifdef IO_PORT_IRQ_EN
  task automatic test_irq();
    logic [15:0] d;
    bus_write(BASE + 16'd2, 16'h0006);
    bus_write(BASE + 16'd2, 16'h0009);
    tick();
    rx_valid = 1'b1; rx_data = 16'h0042; tick();
    rx_valid = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_same_edge: got %b expected 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b expected 1", irq); end
    bus_read(BASE, d);
    checks++;
    if (d !== 16'h0042) begin failures++; $display("FAIL irq_read: got %h expected 0042", d); end
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_overflow();
    test_rx_read();
    test_rx_full_simul();
    test_clear_and_nonhit();
    test_async_reset();
    test_random();
`ifdef IO_PORT_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
